// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit: load funct3 encodings,
// default load-buffer depth and the load-buffer entry layout.
package wb_pkg;

    localparam int LD_DEPTH_DEFAULT = 2;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } ld_funct3_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ld_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return buffer: in-order FIFO of extended load results. Entries whose rd
// is overwritten by a younger execute result are killed but still drain.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = LD_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  ld_entry_t   push_entry,
    input  logic        pop,
    output ld_entry_t   head,
    input  logic        kill_en,
    input  logic [4:0]  kill_rd,
    output logic        full,
    output logic        empty,
    output logic [31:0] busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // NOTE: payload storage is deliberately not reset; live_q and the pointers
    // are, which alone makes every slot invalid after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_entry.rd;
            data_mem[wr_ptr] <= push_entry.data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && rd_mem[i] == kill_rd) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            // An incoming entry is younger than a same-cycle kill, so it is set last.
            if (push) begin
                live_q[wr_ptr] <= push_entry.live;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign head  = '{rd: rd_mem[rd_ptr], data: data_mem[rd_ptr], live: live_q[rd_ptr]};

    // NOTE: default assigned first so no path leaves busy unassigned (no latch).
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                busy[rd_mem[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: execute results win, loads queue behind them.
// Optional performance counters are built when WB_PERF_EN is defined.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int LD_DEPTH = LD_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_word,
    input  logic [1:0]  ld_addr_lo,
    input  logic [2:0]  ld_funct3,
    output logic [4:0]  rd,
    output logic [31:0] rdv,
    output logic        reg_wen,
    output logic [31:0] busy,
    output logic [31:0] perf_writes,
    output logic [31:0] perf_ld_stalls
);

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {lo, 3'b000});
        h = lo[1] ? word[31:16] : word[15:0];
        case (ld_funct3_e'(f3))
            F3_LB:   return {{24{b[7]}}, b};
            F3_LBU:  return {24'd0, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LHU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    ld_entry_t   push_entry;
    ld_entry_t   head;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        bypass;
    logic [31:0] ld_ext;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic        sel_wen;

    assign ld_ext     = extend_load(ld_word, ld_addr_lo, ld_funct3);
    assign push_entry = '{rd: ld_rd, data: ld_ext, live: (ld_rd != 5'd0)};
    assign ld_ready   = !fifo_full;

    wb_load_fifo #(.DEPTH(LD_DEPTH)) u_load_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .kill_en    (ex_valid && ex_rd != 5'd0),
        .kill_rd    (ex_rd),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .busy       (busy)
    );

    // Priority: execute result, then oldest buffered load, then a load that
    // bypasses an empty buffer.
    always_comb begin
        fifo_pop = 1'b0;
        bypass   = 1'b0;
        sel_rd   = ex_rd;
        sel_data = ex_data;
        sel_wen  = 1'b0;
        if (ex_valid) begin
            sel_wen = (ex_rd != 5'd0);
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sel_rd   = head.rd;
            sel_data = head.data;
            sel_wen  = head.live;
        end else if (ld_valid) begin
            bypass   = 1'b1;
            sel_rd   = ld_rd;
            sel_data = ld_ext;
            sel_wen  = (ld_rd != 5'd0);
        end
        fifo_push = ld_valid && ld_ready && !bypass;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd      <= '0;
            rdv     <= '0;
            reg_wen <= 1'b0;
        end else begin
            rd      <= sel_rd;
            rdv     <= sel_data;
            reg_wen <= sel_wen;
        end
    end

`ifdef WB_PERF_EN
    logic [31:0] writes_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writes_q <= '0;
            stalls_q <= '0;
        end else begin
            if (reg_wen) begin
                writes_q <= writes_q + 32'd1;
            end
            if (!fifo_empty && ex_valid) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign perf_writes    = writes_q;
    assign perf_ld_stalls = stalls_q;
`else
    assign perf_writes    = '0;
    assign perf_ld_stalls = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue-based reference model predicts
// register-file writes; a negedge monitor compares every presented write.
module tb_writeback_unit;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_word;
    logic [1:0]  ld_addr_lo;
    logic [2:0]  ld_funct3;
    logic [4:0]  rd;
    logic [31:0] rdv;
    logic        reg_wen;
    logic [31:0] busy;
    logic [31:0] perf_writes;
    logic [31:0] perf_ld_stalls;

    writeback_unit #(.LD_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_data        (ex_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_word        (ld_word),
        .ld_addr_lo     (ld_addr_lo),
        .ld_funct3      (ld_funct3),
        .rd             (rd),
        .rdv            (rdv),
        .reg_wen        (reg_wen),
        .busy           (busy),
        .perf_writes    (perf_writes),
        .perf_ld_stalls (perf_ld_stalls)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] data; bit live; } pend_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wr_t;

    pend_t pend[$];
    wr_t   exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Load extension from the ISA rules using shifts and modular arithmetic.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input int lo, input int f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b < 128)   ? b : b + 32'hFFFF_FF00;
            4:       return b;
            1:       return (h < 32768) ? h : h + 32'hFFFF_0000;
            5:       return h;
            default: return w;
        endcase
    endfunction

    // Drive one cycle of inputs, check buffer-visible state, advance the model.
    task automatic cyc(input bit ev, input logic [4:0] erd, input logic [31:0] edat,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] lw,
                       input logic [1:0] lo, input logic [2:0] f3);
        logic [31:0] exp_busy;
        logic [31:0] ext;
        bit          ready;
        pend_t       h;
        ex_valid = ev; ex_rd = erd; ex_data = edat;
        ld_valid = lv; ld_rd = lrd; ld_word = lw; ld_addr_lo = lo; ld_funct3 = f3;
        #1;
        ready    = (pend.size() < D);
        exp_busy = '0;
        foreach (pend[i]) if (pend[i].live) exp_busy[pend[i].rd] = 1'b1;
        check("ld_ready", {31'd0, ld_ready}, {31'd0, ready});
        check("busy", busy, exp_busy);
        ext = ref_ext(lw, int'(lo), int'(f3));
        if (ev) begin
            if (erd != 0) begin
                exp_q.push_back('{erd, edat});
                foreach (pend[i]) if (pend[i].rd == erd) pend[i].live = 0;
            end
            if (lv && ready) pend.push_back('{lrd, ext, lrd != 0});
        end else if (pend.size() > 0) begin
            h = pend.pop_front();
            if (h.live) exp_q.push_back('{h.rd, h.data});
            if (lv && ready) pend.push_back('{lrd, ext, lrd != 0});
        end else if (lv && lrd != 0) begin
            exp_q.push_back('{lrd, ext});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every presented write must be the oldest predicted one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reg_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got rd=%0d rdv=0x%08h, expected no write", rd, rdv);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rd", {27'd0, rd}, {27'd0, e.rd});
                    check("wr_data", rdv, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        ld_valid = 0; ld_rd = 0; ld_word = 0; ld_addr_lo = 0; ld_funct3 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_rdv", rdv, 32'd0);
        check("rst_wen", {31'd0, reg_wen}, 32'd0);
        check("rst_busy", busy, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Execute write lands one cycle later.
        cyc(1, 5, 32'hDEAE_EFFA, 0, 0, 0, 0, 0);
        // Pass-through loads: LB byte 3 and LHU half 1.
        cyc(0, 0, 0, 1, 7, 32'h80FF_7F01, 3, 3'b000);
        cyc(0, 0, 0, 1, 8, 32'h80FF_7F01, 2, 3'b101);
        idle(2);

        // Continuous execute traffic fills the buffer; loads drain afterwards.
        cyc(1, 1, 32'h1111_1111, 1, 11, 32'hAAAA_0001, 0, 3'b010);
        cyc(1, 2, 32'h2222_2222, 1, 12, 32'hBBBB_0002, 0, 3'b010);
        cyc(1, 3, 32'h3333_3333, 1, 13, 32'hCCCC_0003, 0, 3'b010);
        cyc(1, 4, 32'h4444_4444, 0, 0, 0, 0, 0);
        idle(3);

        // Younger execute write to x10 kills the pending load to x10.
        cyc(1, 1, 32'h0000_0001, 1, 10, 32'h5555_5555, 0, 3'b010);
        cyc(1, 10, 32'hCAFE_CAFE, 0, 0, 0, 0, 0);
        idle(3);

        // x0 destinations never write and never mark busy.
        cyc(1, 0, 32'h1234_5678, 1, 0, 32'h9999_9999, 0, 3'b010);
        cyc(0, 0, 0, 1, 0, 32'h7777_7777, 0, 3'b010);
        idle(2);

        // Reset with two loads pending.
        cyc(1, 1, 32'h0101_0101, 1, 20, 32'hDDDD_0020, 0, 3'b010);
        cyc(1, 2, 32'h0202_0202, 1, 21, 32'hDDDD_0021, 0, 3'b010);
        ex_valid = 0; ld_valid = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_wen", {31'd0, reg_wen}, 32'd0);
        check("mid_rst_rd", {27'd0, rd}, 32'd0);
        check("mid_rst_rdv", rdv, 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        pend.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle(4);

        // Randomised traffic over a small rd range so kills happen often.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end
        idle(6);
        @(negedge clk);
        #1;
        check("drain_pending_writes", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: ex_valid  in  1; ex_rd  in  5; ex_data  in  32. Single-cycle execute result; never stalled.
REQ-004 SHALL have ports: ld_valid  in  1; ld_ready  out  1; ld_rd  in  5; ld_word  in  32 (raw memory word); ld_addr_lo  in  2; ld_funct3  in  3. Load return channel.
REQ-005 SHALL have ports: rd  out  5; rdv  out  32; reg_wen  out  1. Register-file write port.
REQ-006 SHALL have ports: busy  out  32. Bit i set while a load to x(i) is pending.
REQ-007 SHALL have parameter LD_DEPTH, default 2, load buffer entries (power of two, 2..8).

Function
REQ-008 SHALL register rd/rdv/reg_wen: a write selected at edge N is presented throughout cycle N+1, so the register file commits it at edge N+1.
REQ-009 SHALL give ex_valid absolute priority; an ex write is always selected the cycle it arrives.
REQ-010 SHALL accept a load when ld_valid && ld_ready, pushing {rd, extended data} into a FIFO; ld_ready = FIFO not full.
REQ-011 SHALL pop the FIFO head as the write only when ex_valid=0; on an empty FIFO with no ex_valid, an arriving load SHALL pass through with latency 1.
REQ-012 SHALL extend loads: funct3 000 LB / 100 LBU select byte ld_addr_lo; 001 LH / 101 LHU select halfword ld_addr_lo[1]; 010 LW full word; signed variants sign-extend, unsigned zero-extend; other funct3 values behave as LW.
REQ-013 SHALL never assert reg_wen for rd=0; an ex or load with rd=0 is consumed and produces no write and no busy bit.
REQ-014 SHALL, when ex_valid with ex_rd≠0 matches the rd of any pending FIFO entry, kill those entries' writes (entry still drains, reg_wen=0), preserving program order.
REQ-015 SHALL derive busy combinationally from live, unkilled FIFO entries; bit 0 always 0.
REQ-016 SHALL, on a full FIFO with ex_valid=1, hold ld_ready low; no entry is lost or duplicated.
REQ-017 SHALL support simultaneous push and pop in one cycle with occupancy unchanged.

Reset
REQ-018 SHALL on rst clear FIFO pointers and occupancy, and drive rd=0, rdv=0, reg_wen=0, busy=0, ld_ready=1 (after reset releases).
REQ-019 SHALL discard pending loads when rst asserts mid-operation; no write after release.

Configuration
REQ-020 SHALL compile with WB_PERF_EN: adds outputs perf_writes (32, counts reg_wen cycles) and perf_ld_stalls (32, counts cycles with FIFO non-empty and ex_valid=1), both reset to 0, wrapping at 2^32.
REQ-021 SHALL without WB_PERF_EN omit both counters; ports remain present, tied to 0.

Structure
REQ-022 SHALL place the load funct3 encodings, the LD_DEPTH default and the FIFO entry struct {rd, data, live} in package wb_pkg.
REQ-023 SHALL implement the load buffer as sub-module wb_load_fifo (push/pop/full/empty, kill-by-rd input); extension logic stays in writeback_unit.

Verification
REQ-024 SHALL cover: ex_valid, ex_rd=5, ex_data=0xDEAEEFFA -> next cycle rd=5, rdv=0xDEAEEFFA, reg_wen=1.
REQ-025 SHALL cover: LB, ld_word=0x80FF7F01, ld_addr_lo=3 -> rdv=0xFFFFFF80; LHU, same word, addr_lo=2 -> rdv=0x000080FF.
REQ-026 SHALL cover: ex_valid every cycle while two loads arrive -> ld_ready falls after 2 accepts, busy shows both rd bits, loads write in order once ex_valid drops.
REQ-027 SHALL cover: pending load to x10 then ex write x10=0xCAFECAFE -> x10 written 0xCAFECAFE, load drains with reg_wen=0, busy[10] clears.
REQ-028 SHALL cover: ex_rd=0, ex_data=0x12345678 and a load to x0 -> reg_wen never 1, busy=0.
REQ-029 SHALL cover: rst asserted with 2 pending loads -> outputs 0 asynchronously, no writes after release, ld_ready=1.
